// File: rtl/fp_add_arbiter_if.sv
// Request/response bus between NUM_REQ requesters and the shared FP adder arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface fp_add_arbiter_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7,
  parameter int NUM_REQ    = 2
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][W-1:0] req_op1;
  logic [NUM_REQ-1:0][W-1:0] req_op2;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [W-1:0]              rsp_result;
  logic                      rsp_overflow;

  modport master (
    output req_valid, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP adder datapath between NUM_REQ requesters.
// One operation in flight: grant, hold operands on the datapath for
// DP_LATENCY+1 cycles, capture the result, then present it to the winner.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no op in flight; arbitrate among req_valid, accept the winner
// EXEC  | captured operands on dp_op*; down-counter runs to terminal count
// RESP  | captured result offered to the granted requester until rsp_ready
module fp_add_arbiter #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7,
  parameter int NUM_REQ    = 2,
  parameter int DP_LATENCY = 0,
  localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int GW = $clog2(NUM_REQ),
  localparam int LW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_add_arbiter_if.slave      bus,
  output logic [W-1:0]         dp_op1,
  output logic [W-1:0]         dp_op2,
  input  logic [W-1:0]         dp_result,
  input  logic                 dp_overflow,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_grant_q;
  logic [GW-1:0]   gnt_q;
  logic [LW-1:0]   lat_cnt_q;
  logic [W-1:0]    op1_q, op2_q;
  logic [W-1:0]    res_q;
  logic            ovf_q;
  logic [15:0]     done_cnt_q, done_cnt_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand;
  logic            accept;
  logic            exec_last;
  logic            rsp_hs;

  // Round-robin pick: first valid requester after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    accept        = 1'b0;
    exec_last     = 1'b0;
    rsp_hs        = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !rst) begin
          bus.req_ready[win_idx] = 1'b1;
          accept                 = 1'b1;
          state_d                = EXEC;
        end
      end
      EXEC: begin
        exec_last = (lat_cnt_q == '0);
        if (exec_last) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[gnt_q]) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response valid is one-hot on the granted requester while in RESP.
  always_comb begin
    bus.rsp_valid = '0;
    if (state_q == RESP) bus.rsp_valid[gnt_q] = 1'b1;
  end

  // Counter is written every cycle so the register always tracks done_cnt_d.
  always_comb begin
    done_cnt_d = done_cnt_q + {15'd0, rsp_hs};
  end

  // State, captured operands/result, latency timer and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      gnt_q        <= '0;
      lat_cnt_q    <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_cnt_q <= done_cnt_d;
      if (accept) begin
        op1_q        <= bus.req_op1[win_idx];
        op2_q        <= bus.req_op2[win_idx];
        gnt_q        <= win_idx;
        last_grant_q <= win_idx;
        lat_cnt_q    <= LW'(DP_LATENCY);
      end else if (state_q == EXEC && !exec_last) begin
        lat_cnt_q <= lat_cnt_q - 1'b1;
      end
      if (exec_last) begin
        res_q <= dp_result;
        ovf_q <= dp_overflow;
      end
    end
  end

  // Operand registers only change on accept, so the datapath inputs stay
  // quiet outside EXEC.
  assign dp_op1           = op1_q;
  assign dp_op2           = op2_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_overflow = ovf_q;
  assign busy             = (state_q != IDLE);
  assign done_cnt         = done_cnt_q;

endmodule
